square_u16: RTL

Unsigned 16-bit integer squarer: accepts a stream of operands on a valid-only input, buffers them in a FIFO, and returns y = x·x as an exact 32-bit result, computed with an iterative shift-add datapath. It is the inverse companion of the 32-bit square-root block: it produces the operands that block consumes, and it checks its results in the verification environment, where y² ≤ x < (y+1)² must hold. It is also a reusable low-area squarer for the datapath.

---
 rtl/arith_pkg.sv | 20 ++
 rtl/fifo.sv | 64 ++++++
 rtl/square_u16.sv | 132 +++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic constants and FSM encoding for the squarer and the
// companion 32-bit square-root block.
//   OPERAND_W : width of the squarer operand (and of the square-root result)
//   RESULT_W  : width of the squared result (and of the square-root operand)
//   ITER      : shift-add iterations per operation (one per operand bit)
//   CNT_W     : width of the iteration counter
package arith_pkg;

    localparam int OPERAND_W = 16;
    localparam int RESULT_W  = 2 * OPERAND_W;
    localparam int ITER      = 16;
    localparam int CNT_W     = $clog2(ITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2
    } arith_state_e;

endpackage

// File: rtl/fifo.sv
// Synchronous single-clock FIFO with registered read data.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   wr_en      : push wr_data when not full
//   wr_data    : data to push
//   rd_en      : pop when not empty; rd_data is valid the cycle after the pop
//   rd_data    : registered read data
//   empty      : no words held
//   full       : DEPTH words held (combinational from the count)
module fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_reg;
    logic [AW-1:0]         wr_ptr_reg;
    logic [AW-1:0]         rd_ptr_reg;
    logic [AW:0]           count_reg;
    logic                  do_wr;
    logic                  do_rd;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = rd_data_reg;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage and read register carry no reset so they map onto block RAM.
    // A read never targets the slot being written: reads need a non-empty
    // FIFO and writes need a non-full one, so the pointers differ.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_reg] <= wr_data;
        if (do_rd) rd_data_reg <= mem[rd_ptr_reg];
    end

endmodule

// File: rtl/square_u16.sv
// Unsigned 16-bit squarer: buffers operands in a FIFO and computes y = x*x
// with a 16-iteration shift-add datapath.
//   clk, rst_n : clock, asynchronous active-low reset
//   vld_in, x  : operand stream, no backpressure
//   full       : input FIFO full (operands offered now are dropped)
//   ovf        : sticky, an operand was dropped
//   vld_out    : one-cycle pulse, y holds a new result
//   y          : latest result, held until the next one
module square_u16
    import arith_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                vld_in,
    input  logic [OPERAND_W-1:0] x,
    output logic                full,
    output logic                ovf,
    output logic                vld_out,
    output logic [RESULT_W-1:0] y
);

    arith_state_e          state_reg;
    arith_state_e          state_next;
    logic                  rd_en;
    logic                  fifo_empty;
    logic [OPERAND_W-1:0]  fifo_rd_data;

    logic [OPERAND_W-1:0]  mcand_reg;
    logic [OPERAND_W-1:0]  mplier_reg;
    logic [RESULT_W-1:0]   acc_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic                  ovf_reg;
    logic                  vld_out_reg;
    logic [RESULT_W-1:0]   y_reg;

    logic [RESULT_W-1:0]   term [ITER];
    logic [RESULT_W-1:0]   acc_sum;
    logic                  last_iter;

    fifo #(
        .DATA_WIDTH (OPERAND_W),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (vld_in),
        .wr_data (x),
        .rd_en   (rd_en),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (full)
    );

    // Table of multiplicand shifted by each bit position; the counter picks
    // the partial product for the current iteration.
    generate
        for (genvar gi = 0; gi < ITER; gi++) begin : g_term
            assign term[gi] = {{(RESULT_W-OPERAND_W){1'b0}}, mcand_reg} << gi;
        end
    endgenerate

    assign acc_sum   = acc_reg + (mplier_reg[cnt_reg] ? term[cnt_reg] : '0);
    assign last_iter = (cnt_reg == CNT_W'(ITER - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (!fifo_empty) state_next = LOAD;
            LOAD:    state_next = CALC;
            CALC:    if (last_iter) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: pop exactly one word per operation, from IDLE only.
    always_comb begin
        rd_en = 1'b0;
        if (state_reg == IDLE && !fifo_empty) rd_en = 1'b1;
    end

    // Shift-add datapath and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            vld_out_reg <= 1'b0;
            y_reg       <= '0;
        end else begin
            vld_out_reg <= 1'b0;
            case (state_reg)
                LOAD: begin
                    mcand_reg  <= fifo_rd_data;
                    mplier_reg <= fifo_rd_data;
                    acc_reg    <= '0;
                    cnt_reg    <= '0;
                end
                CALC: begin
                    acc_reg <= acc_sum;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (last_iter) begin
                        y_reg       <= acc_sum;
                        vld_out_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Drop flag: the write is refused whenever full, even if a pop happens
    // on the same edge, so this mirrors the FIFO's own write gate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              ovf_reg <= 1'b0;
        else if (vld_in && full) ovf_reg <= 1'b1;
    end

    assign ovf     = ovf_reg;
    assign vld_out = vld_out_reg;
    assign y       = y_reg;

endmodule
